// File: rtl/oam_scan_if.sv
// oam_scan_if: OAM read-port bundle between the mode-2 scanner and the OAM block.
//   adb  : word address (7 bits, word w holds bytes 2w/2w+1)
//   ceb  : read clock enable
//   oce  : output enable, always equal to ceb
//   dout : read data, [7:0] = Y byte, [15:8] = X byte (one cycle after ceb)
// master = scanner side, slave = OAM memory side.
interface oam_scan_if;
  logic [6:0]  adb;
  logic        ceb;
  logic        oce;
  logic [15:0] dout;

  modport master (output adb, output ceb, output oce, input dout);
  modport slave  (input adb, input ceb, input oce, output dout);
endinterface

// File: rtl/oam_scan.sv
// oam_scan: mode-2 OAM scan sequencer. On an accepted start it reads all
// NUM_ENTRIES OAM entries (2 cycles each) and records the first MAX_SPRITES
// sprites whose Y range covers the latched line, in OAM order.
// Ports:
//   clk, resetn       : clock, synchronous active-low reset
//   start, ly, tall   : scan request, current line, 8x16 object size
//   oam               : OAM read port (master side)
//   busy, done, count : scanning, one-cycle list-final pulse, list length
//   rd_idx            : list slot to read; rd_oam_idx / rd_x are combinational
// Build option: define OAM_SCAN_TALL_EN to honour tall (height 16); otherwise
// the height is fixed at 8 and tall is ignored.
//
// state | meaning
// IDLE  | waiting for start; list and count hold
// SCAN  | walking OAM, phase 0 = issue read, phase 1 = evaluate entry
// DONE  | one cycle, done pulse; a start here re-enters SCAN directly
module oam_scan #(
  parameter int NUM_ENTRIES = 40,
  parameter int MAX_SPRITES = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  ly,
  input  logic        tall,
  oam_scan_if.master  oam,
  output logic        busy,
  output logic        done,
  output logic [3:0]  count,
  input  logic [3:0]  rd_idx,
  output logic [5:0]  rd_oam_idx,
  output logic [7:0]  rd_x
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [5:0] LAST_ENTRY = 6'(NUM_ENTRIES - 1);
  localparam logic [3:0] MAX_CNT    = 4'(MAX_SPRITES);

  state_t      state, state_nx;
  logic        accept;
  logic        rd_ce;
  logic [5:0]  entry;
  logic        phase;
  logic [7:0]  ly_q;
  logic [3:0]  count_q;
  logic [6:0]  adb_q;
  logic [5:0]  slot_idx [MAX_SPRITES];
  logic [7:0]  slot_x   [MAX_SPRITES];
  logic [9:0]  diff;
  logic [8:0]  height;
  logic        hit;

`ifdef OAM_SCAN_TALL_EN
  logic tall_q;

  always_ff @(posedge clk) begin
    if (!resetn)     tall_q <= 1'b0;
    else if (accept) tall_q <= tall;
  end

  assign height = tall_q ? 9'd16 : 9'd8;
`else
  logic unused_tall;
  assign unused_tall = tall;
  assign height      = 9'd8;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    rd_ce    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        busy  = 1'b1;
        rd_ce = ~phase;
        if (phase && entry == LAST_ENTRY) state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = S_SCAN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Extra top bit catches the borrow when Y > ly + 16.
  assign diff = {2'b00, ly_q} + 10'd16 - {2'b00, oam.dout[7:0]};
  assign hit  = ~diff[9] && (diff[8:0] < height);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      entry   <= '0;
      phase   <= 1'b0;
      ly_q    <= '0;
      count_q <= '0;
      adb_q   <= '0;
      for (int i = 0; i < MAX_SPRITES; i++) begin
        slot_idx[i] <= '0;
        slot_x[i]   <= '0;
      end
    end else if (accept) begin
      ly_q    <= ly;
      count_q <= '0;
      entry   <= '0;
      phase   <= 1'b0;
      for (int i = 0; i < MAX_SPRITES; i++) begin
        slot_idx[i] <= '0;
        slot_x[i]   <= '0;
      end
    end else if (state == S_SCAN) begin
      if (!phase) begin
        adb_q <= {entry, 1'b0};
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        entry <= entry + 6'd1;
        // Overflow hits are dropped but the walk continues for fixed timing.
        if (hit && count_q < MAX_CNT) begin
          slot_idx[count_q] <= entry;
          slot_x[count_q]   <= oam.dout[15:8];
          count_q           <= count_q + 4'd1;
        end
      end
    end
  end

  // Address holds its last issued value while the read port is disabled.
  assign oam.adb = rd_ce ? {entry, 1'b0} : adb_q;
  assign oam.ceb = rd_ce;
  assign oam.oce = rd_ce;

  assign count      = count_q;
  assign rd_oam_idx = (rd_idx < count_q) ? slot_idx[rd_idx] : 6'd0;
  assign rd_x       = (rd_idx < count_q) ? slot_x[rd_idx]   : 8'd0;

endmodule
